// File: rtl/load_store_unit.sv
// Load/store unit: turns a single byte/halfword/word access request into
// word-wide memory cycles. Loads read the word and extract/extend the
// addressed lane; sub-word stores do a read-modify-write; word stores write
// directly. Misaligned or illegal-size requests finish with an error and
// never touch memory.
//
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   req_*         - request channel (valid/ready handshake), store data right-aligned
//   resp_valid    - one-cycle completion pulse
//   resp_rdata    - extended load data (0 for stores and errors), held until next response
//   resp_err      - misaligned / illegal-size flag, held until next response
//   mem_we        - word write enable to data memory
//   mem_a         - word-aligned memory address (0 while idle)
//   mem_di        - memory write data
//   mem_rd        - combinational memory read data
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_di,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_READ,
        WRITE,
        RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t                  state;
    logic                    l_we;
    logic [1:0]              l_size;
    logic                    l_unsigned;
    logic [ADDR_WIDTH-1:0]   l_addr;
    logic [DATA_WIDTH-1:0]   l_wdata;
    logic [DATA_WIDTH-1:0]   rmw_word;

    logic                    req_bad;
    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;
    logic [DATA_WIDTH-1:0]   load_ext;
    logic [DATA_WIDTH-1:0]   merged;

    assign req_ready = (state == IDLE) && !rst;
    assign mem_we    = (state == WRITE) && !rst;
    assign mem_a     = (state == IDLE) ? '0 : {l_addr[ADDR_WIDTH-1:2], 2'b00};

    // Error classification is done on the live request inputs so the error
    // path can go straight to RESP on the handshake edge.
    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            SZ_BYTE: req_bad = 1'b0;
            SZ_HALF: req_bad = req_addr[0];
            SZ_WORD: req_bad = (req_addr[1:0] != 2'b00);
            default: req_bad = 1'b1;
        endcase
    end

    // Lane extraction and extension for loads.
    always_comb begin
        byte_sel = mem_rd[{l_addr[1:0], 3'b000} +: 8];
        half_sel = mem_rd[{l_addr[1], 4'b0000} +: 16];
        case (l_size)
            SZ_BYTE: load_ext = {{24{byte_sel[7]  & ~l_unsigned}}, byte_sel};
            SZ_HALF: load_ext = {{16{half_sel[15] & ~l_unsigned}}, half_sel};
            default: load_ext = mem_rd;
        endcase
    end

    // Write data: word stores pass through; sub-word stores splice the new
    // lane into the word captured during RMW_READ.
    always_comb begin
        merged = rmw_word;
        case (l_size)
            SZ_BYTE: merged[{l_addr[1:0], 3'b000} +: 8]  = l_wdata[7:0];
            SZ_HALF: merged[{l_addr[1], 4'b0000} +: 16]  = l_wdata[15:0];
            default: merged = l_wdata;
        endcase
        mem_di = (state == WRITE) ? merged : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            l_we       <= 1'b0;
            l_size     <= '0;
            l_unsigned <= 1'b0;
            l_addr     <= '0;
            l_wdata    <= '0;
            rmw_word   <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        l_we       <= req_we;
                        l_size     <= req_size;
                        l_unsigned <= req_unsigned;
                        l_addr     <= req_addr;
                        l_wdata    <= req_wdata;
                        if (req_bad) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (!req_we) begin
                            state <= LOAD;
                        end else if (req_size == SZ_WORD) begin
                            state <= WRITE;
                        end else begin
                            state <= RMW_READ;
                        end
                    end
                end
                LOAD: begin
                    resp_rdata <= load_ext;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RMW_READ: begin
                    rmw_word <= mem_rd;
                    state    <= WRITE;
                end
                WRITE: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_di;
    logic [31:0] mem_rd;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_di(mem_di), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: 16 words, combinational read, clocked write.
    logic [31:0] mem [0:15];
    assign mem_rd = mem[mem_a[5:2]];
    always @(posedge clk) if (mem_we) mem[mem_a[5:2]] <= mem_di;

    int cyc = 0;
    int wecount = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) wecount <= wecount + 1;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t q[$];

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resp_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                chk("resp_latency", cyc, e.cyc);
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int lat);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        q.push_back('{exp_rdata, exp_err, cyc + lat});
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("resp_timeout", 32'd0, 32'd1);
            q.delete();
        end
    endtask

    initial begin
        int w0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0] = 32'hCAFEF00D;
        mem[2] = 32'h11223344;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Word store then load
        w0 = wecount;
        issue(1'b1, 2'b10, 1'b0, 32'h4, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        chk("mem1_word", mem[1], 32'hDEADBEEF);
        chk("we_cnt_word", wecount - w0, 1);
        issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'hDEADBEEF, 1'b0, 2);

        // Byte store (read-modify-write)
        w0 = wecount;
        issue(1'b1, 2'b00, 1'b0, 32'hA, 32'h123456AA, 32'h0, 1'b0, 3);
        chk("mem2_byte", mem[2], 32'h11AA3344);
        chk("we_cnt_byte", wecount - w0, 1);

        // Sub-word loads
        issue(1'b0, 2'b00, 1'b0, 32'hA, 32'h0, 32'hFFFFFFAA, 1'b0, 2);
        issue(1'b0, 2'b00, 1'b1, 32'hA, 32'h0, 32'h000000AA, 1'b0, 2);
        issue(1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 32'h000011AA, 1'b0, 2);
        issue(1'b0, 2'b00, 1'b0, 32'h8, 32'h0, 32'h00000044, 1'b0, 2);

        // Half store into upper lane, then read back both ways
        issue(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000BEEF, 32'h0, 1'b0, 3);
        chk("mem1_half", mem[1], 32'hBEEFBEEF);
        issue(1'b0, 2'b01, 1'b1, 32'h4, 32'h0, 32'h0000BEEF, 1'b0, 2);
        issue(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 32'hFFFFBEEF, 1'b0, 2);
        issue(1'b0, 2'b00, 1'b1, 32'h7, 32'h0, 32'h000000BE, 1'b0, 2);

        // Error requests: no memory writes, immediate response
        w0 = wecount;
        issue(1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 32'h0, 1'b1, 1);
        issue(1'b1, 2'b10, 1'b0, 32'h6, 32'h55555555, 32'h0, 1'b1, 1);
        issue(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1);
        issue(1'b1, 2'b11, 1'b0, 32'h0, 32'h66666666, 32'h0, 1'b1, 1);
        chk("we_cnt_err", wecount - w0, 0);
        chk("mem0_err", mem[0], 32'hCAFEF00D);
        chk("mem1_err", mem[1], 32'hBEEFBEEF);

        // Leave nonzero load data in the response register
        issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'hBEEFBEEF, 1'b0, 2);

        // Reset during WRITE of a word store
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h0;
        req_wdata = 32'h12345678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("write_state_we", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_gates_we", {31'd0, mem_we}, 32'd0);
        chk("rst_gates_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("rst_write_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_write_rdata", resp_rdata, 32'd0);
        chk("rst_write_err", {31'd0, resp_err}, 32'd0);
        chk("mem0_unchanged", mem[0], 32'hCAFEF00D);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst2", {31'd0, req_ready}, 32'd1);
        repeat (4) @(negedge clk);
        chk("mem0_final", mem[0], 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
